// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the SR-flag lock controller: FSM state encoding and
// an index-width helper for the requester count.
package sr_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t HOLD  = 2'd1;
  localparam state_t CLEAR = 2'd2;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set req bit at or above
// ptr, wrapping modulo N_REQ.
module rr_pick
  import sr_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  logic [IW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest set bit wins last.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = IW'((int'(ptr) + off) % N_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sr_lock_arbiter.sv
// Round-robin lock controller sharing one SR status flag among N_REQ agents,
// with one-cycle set/clear pulses and a hold timeout that reclaims the lock.
module sr_lock_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         rel,
  output logic [N_REQ-1:0]         grant,
  output logic [idx_w(N_REQ)-1:0]  owner,
  output logic                     busy,
  output logic                     lock_set,
  output logic                     lock_clr,
  output logic                     timeout
);

  localparam int IW = idx_w(N_REQ);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               lock_set_q, lock_set_d;
  logic               lock_clr_q, lock_clr_d;
  logic               timeout_q, timeout_d;

  logic               pick_valid;
  logic [IW-1:0]      pick_idx;
  logic               rel_own;
  logic               expire;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign rel_own = rel[owner_q];
  assign expire  = TO_EN && (cnt_q == EXP_CNT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_valid) state_d = HOLD;
      HOLD:    if (rel_own || expire) state_d = CLEAR;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead from the upcoming state so they leave as registers.
  always_comb begin
    grant_d    = '0;
    owner_d    = owner_q;
    busy_d     = 1'b0;
    lock_set_d = 1'b0;
    lock_clr_d = 1'b0;
    timeout_d  = 1'b0;
    unique case (state_d)
      HOLD: begin
        busy_d = 1'b1;
        if (state_q == IDLE) begin
          grant_d    = N_REQ'(1) << pick_idx;
          owner_d    = pick_idx;
          lock_set_d = 1'b1;
        end else begin
          grant_d = grant_q;
        end
      end
      // CLEAR is only reached from HOLD; an owner release takes priority over expiry.
      CLEAR: begin
        lock_clr_d = 1'b1;
        timeout_d  = ~rel_own;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    if (state_q == HOLD && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == CLEAR) begin
      cnt_d = '0;
      ptr_d = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      lock_set_q <= 1'b0;
      lock_clr_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      lock_set_q <= lock_set_d;
      lock_clr_q <= lock_clr_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign owner    = owner_q;
  assign busy     = busy_q;
  assign lock_set = lock_set_q;
  assign lock_clr = lock_clr_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_sr_lock_arbiter.sv
// Self-checking bench for sr_lock_arbiter: directed scenarios plus random
// traffic against a transaction-level lock model and an attached SR flag.
module tb_sr_lock_arbiter;

  localparam int N  = 4;
  localparam int TO = 5;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] rel = '0;
  logic [N-1:0] grant;
  logic [1:0]   owner;
  logic         busy, lock_set, lock_clr, timeout;

  sr_lock_arbiter #(.N_REQ(N), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .req      (req),
    .rel      (rel),
    .grant    (grant),
    .owner    (owner),
    .busy     (busy),
    .lock_set (lock_set),
    .lock_clr (lock_clr),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Downstream SR flag driven by the pulses, reset by the same net.
  logic sr_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sr_q <= 1'b0;
    else if (lock_set) sr_q <= 1'b1;
    else if (lock_clr) sr_q <= 1'b0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who holds the lock, how many grant cycles have elapsed,
  // and whether the one-cycle clear phase is in progress.
  logic [N-1:0] e_grant;
  int           e_owner, m_ptr, m_held;
  bit           e_busy, e_set, e_clr, e_to, m_clearing;
  logic         busy_prev;

  task automatic model_reset();
    e_grant = '0; e_owner = 0; e_busy = 0; e_set = 0; e_clr = 0; e_to = 0;
    m_ptr = 0; m_held = 0; m_clearing = 0;
  endtask

  task automatic model_edge();
    bit found;
    e_set = 0; e_clr = 0; e_to = 0;
    if (m_clearing) begin
      m_clearing = 0;
    end else if (e_busy) begin
      m_held++;
      if (rel[e_owner] || m_held == TO) begin
        e_to       = !rel[e_owner];
        e_clr      = 1;
        e_busy     = 0;
        e_grant    = '0;
        m_ptr      = (e_owner + 1) % N;
        m_clearing = 1;
      end
    end else if (req != '0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req[(m_ptr + k) % N]) begin
          found   = 1;
          e_owner = (m_ptr + k) % N;
        end
      end
      e_grant = '0;
      e_grant[e_owner] = 1'b1;
      e_busy = 1; e_set = 1; m_held = 0;
    end
  endtask

  task automatic compare_all();
    check("grant",    grant,    e_grant);
    check("owner",    owner,    e_owner);
    check("busy",     busy,     e_busy);
    check("lock_set", lock_set, e_set);
    check("lock_clr", lock_clr, e_clr);
    check("timeout",  timeout,  e_to);
    check("sr_q",     sr_q,     busy_prev);
    check("s_r_excl", lock_set & lock_clr, 1'b0);
    busy_prev = busy;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all();
  endtask

  // Asserted away from the clock edge; outputs must clear without waiting for a clock.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    busy_prev = 1'b0;
    compare_all();
    step();
    step();
    rst_n = 1'b1;
  endtask

  int hi, cnt, n_grants, n_clr;
  logic [N-1:0] order [5];
  logic [N-1:0] exp_order [5];

  initial begin
    model_reset();
    busy_prev = 1'b0;
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    #2;
    apply_reset();

    // Reset mid-HOLD, then the pointer must start from 0 again.
    req = 4'b0100;
    step(); step(); step();
    check("pre_reset_busy", busy, 1'b1);
    req = '0;
    apply_reset();
    check("reset_grant", grant, 4'b0000);
    req = 4'b1000;
    step();
    check("post_reset_grant", grant, 4'b1000);
    req = '0;
    apply_reset();

    // Round-robin with release after three grant cycles.
    req = 4'b1111; n_grants = 0; n_clr = 0; cnt = 0;
    for (int c = 0; c < 60 && n_grants < 5; c++) begin
      step();
      if (lock_set) begin
        order[n_grants] = grant;
        n_grants++;
      end
      if (lock_clr) n_clr++;
      cnt = busy ? cnt + 1 : 0;
      rel = (busy && cnt == 3) ? grant : '0;
    end
    check("rr_count", n_grants, 5);
    for (int i = 0; i < n_grants; i++) check("rr_order", order[i], exp_order[i]);
    check("rr_clears", n_clr, 4);
    req = '0; rel = '0;
    apply_reset();

    // Timeout with no release.
    req = 4'b0010; hi = 0;
    for (int c = 0; c < 30 && !lock_clr; c++) begin
      step();
      if (grant != '0) hi++;
      if (lock_set) req = '0;
    end
    check("to_hold_cycles", hi, TO);
    check("to_clr", lock_clr, 1'b1);
    check("to_pulse", timeout, 1'b1);
    step();
    check("to_pulse_len", timeout, 1'b0);
    apply_reset();

    // Release arriving on the expiry cycle counts as a release.
    req = 4'b0100; hi = 0;
    for (int c = 0; c < 30 && !lock_clr; c++) begin
      step();
      if (grant != '0) hi++;
      if (lock_set) req = '0;
      rel = (hi == TO && grant != '0) ? 4'b0100 : '0;
    end
    check("sim_hold_cycles", hi, TO);
    check("sim_clr", lock_clr, 1'b1);
    check("sim_timeout", timeout, 1'b0);
    rel = '0;
    apply_reset();

    // Release from a non-owner is ignored.
    req = 4'b0001;
    step();
    rel = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step();
      check("nonown_grant", grant, 4'b0001);
      check("nonown_clr", lock_clr, 1'b0);
    end
    rel = '0; req = '0;
    apply_reset();

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        apply_reset();
      end
      req = N'($urandom);
      rel = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_lock_arbiter.md
# sr_lock_arbiter

Round-robin lock controller that shares one set/reset status flag (the team's SR flip-flop) among N_REQ requesters. It grants exclusive ownership to one requester at a time and drives one-cycle set/clear pulses to the downstream SR flip-flop. A hold timeout reclaims the lock from a requester that never releases it. It sits between the requesting agents and the flag register.

## Interface
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT, 255, maximum HOLD cycles before forced release; 0 disables timeout
- CNT_W, 8, hold counter width; must satisfy 2**CNT_W > TIMEOUT
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req  in  N_REQ  per-requester lock request, level
- rel  in  N_REQ  per-requester release, level; only the owner's bit is honoured
- grant  out  N_REQ  one-hot ownership, registered
- owner  out  $clog2(N_REQ)  index of current/last owner, registered
- busy  out  1  lock held (state HOLD)
- lock_set  out  1  one-cycle pulse to flop S input when the lock is taken
- lock_clr  out  1  one-cycle pulse to flop R input when the lock is freed
- timeout  out  1  one-cycle pulse when the release was forced by timeout

## Operation
- States: IDLE, HOLD, CLEAR.
- IDLE: grant=0, busy=0. If any req bit is set, the winner is the first set bit at or above ptr, wrapping modulo N_REQ. Next state HOLD, grant=onehot(winner), owner=winner, lock_set=1 for the first HOLD cycle only.
- HOLD: grant and busy held, hold counter increments each cycle (saturating). Exits to CLEAR on rel[owner]=1 or (TIMEOUT!=0 and counter==TIMEOUT-1). req[owner] dropping does not release. rel from non-owners is ignored.
- CLEAR: grant=0, busy=0, lock_clr=1, timeout=1 if the exit was forced. ptr=(owner+1) mod N_REQ, counter=0. Next state is always IDLE.
- lock_set and lock_clr are never both high. Together they never produce S=R=1 at the flop.
- Simultaneous rel[owner] and timeout expiry are treated as a release: timeout=0.
- rel[i] together with req[i] while IDLE: rel is ignored and the request proceeds.
- Reset asserted (any state): state=IDLE, ptr=0, counter=0, all outputs 0 immediately. No lock_clr pulse is issued; the flop is reset by the same reset net.

## Timing
- Reset values: grant=0, owner=0, busy=0, lock_set=0, lock_clr=0, timeout=0.
- All outputs are registered. No combinational path from inputs to outputs.
- req sampled high in IDLE at edge k: grant/lock_set/busy high after edge k.
- rel[owner] sampled at edge k: grant drops and lock_clr pulses after edge k; a new grant can appear no earlier than after edge k+2.
- Maximum hold is TIMEOUT cycles of grant high. lock_clr follows on the next cycle.
- Fairness: a requester holding req continuously is granted within N_REQ-1 other grants.

## Structure
- Shared package/header sr_ctrl_pkg: state encoding localparams (IDLE=2'd0, HOLD=2'd1, CLEAR=2'd2) and an index-width function for N_REQ.
- Sub-module rr_pick: combinational round-robin picker. Inputs are req and ptr; outputs are a valid flag and the winning index. Instantiate it once.
- The FSM, ptr, hold counter and output registers stay in sr_lock_arbiter.

## Test plan
- Reset mid-HOLD: hold reset=0 for 2 cycles during a grant -> all outputs 0 immediately, ptr=0. After release, req=4'b1000 -> grant=4'b1000.
- Round-robin: req=4'b1111 held, each owner pulses rel after 3 cycles -> grant order 0001,0010,0100,1000,0001, with one CLEAR cycle (lock_clr=1) between grants.
- Timeout: TIMEOUT=5, req=4'b0010 and never rel -> grant high exactly 5 cycles, then lock_clr=1 and timeout=1 for one cycle.
- Simultaneous release and expiry: rel[owner] on the expiry cycle -> lock_clr=1, timeout=0.
- Non-owner release: owner=0, rel=4'b0100 -> grant stays 4'b0001, no lock_clr.
- Flop integration: lock_set/lock_clr drive an SR flip-flop's s/r -> its q equals busy delayed by one cycle. The flop never sees s=r=1.
